// File: rtl/imem_arbiter_pkg.sv
// Shared encodings for the instruction-memory arbiter: response owner tags,
// loader lock states, fetch starvation limit and the debug view of internal state.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_e;

  localparam int unsigned     STARVE_W     = 4;
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = 4'd15;

  typedef struct packed {
    lock_e               lock;
    owner_e              owner;
    logic [STARVE_W-1:0] starve;
    logic                rr_prio_fetch;
  } dbg_t;

  // Which requester owns the read response launched by this cycle's grant.
  function automatic owner_e owner_for(input logic f_gnt, input logic l_gnt,
                                       input logic l_we);
    owner_e v;
    v = OWN_NONE;
    if (f_gnt)               v = OWN_FETCH;
    else if (l_gnt && !l_we) v = OWN_LOAD;
    return v;
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a contested cycle goes to the requester that was
// not granted most recently; the priority bit only moves when something is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_prio_fetch
);

  logic r_prio_fetch;

  always_comb begin
    o_gnt    = 2'b00;
    o_gnt[0] = i_req[0] & (~i_req[1] | r_prio_fetch);
    o_gnt[1] = i_req[1] & (~i_req[0] | ~r_prio_fetch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_fetch <= 1'b1;
    end else if (o_gnt[0]) begin
      r_prio_fetch <= 1'b0;
    end else if (o_gnt[1]) begin
      r_prio_fetch <= 1'b1;
    end
  end

  assign o_prio_fetch = r_prio_fetch;

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the fetch stage and the loader/debug port onto one synchronous
// instruction RAM, with loader burst locking and a fetch starvation guard.
//
// Handshake: a requester holds req (and its address/data) until it sees its
// gnt high in the same cycle; a granted read returns rvalid for exactly one
// cycle, one cycle later, with rdata taken straight from the memory.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output dbg_t              o_dbg
);

  lock_e               r_lock;
  owner_e              r_owner;
  logic [STARVE_W-1:0] r_starve;
  logic [ADDR_W-1:0]   r_addr_hold;
  logic [DATA_W-1:0]   r_wdata_hold;
  logic [DATA_W-1:0]   r_f_rdata;
  logic [DATA_W-1:0]   r_l_rdata;

  logic       w_f_force;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_prio_fetch;

  // A starved fetch overrides both the lock and the round-robin order.
  assign w_f_force = f_req & (r_starve == STARVE_LIMIT);

  always_comb begin
    w_req    = 2'b00;
    w_req[0] = rst_n & f_req & (w_f_force | (r_lock == LK_UNLOCKED));
    w_req[1] = rst_n & l_req & ~w_f_force;
  end

  rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (w_req),
    .o_gnt        (w_gnt),
    .o_prio_fetch (w_prio_fetch)
  );

  assign f_gnt   = w_gnt[0];
  assign l_gnt   = w_gnt[1];
  assign f_stall = f_req & ~f_gnt;

  // Fetch carries no write data, so mem_wdata only follows loader grants.
  always_comb begin
    mem_en    = f_gnt | l_gnt;
    mem_we    = l_gnt & l_we;
    mem_addr  = r_addr_hold;
    mem_wdata = r_wdata_hold;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (l_gnt) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else if (f_gnt) begin
      r_addr_hold <= f_addr;
    end else if (l_gnt) begin
      r_addr_hold  <= l_addr;
      r_wdata_hold <= l_wdata;
    end
  end

  // Loader burst lock; an idle loader cycle always releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= LK_UNLOCKED;
    end else begin
      case (r_lock)
        LK_UNLOCKED: if (l_gnt & l_lock) r_lock <= LK_LOCKED;
        LK_LOCKED:   if ((l_gnt & ~l_lock) | ~l_req) r_lock <= LK_UNLOCKED;
        default:     r_lock <= LK_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (f_gnt | ~f_req) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_LIMIT) begin
      r_starve <= r_starve + {{(STARVE_W-1){1'b0}}, 1'b1};
    end
  end

  // Owner tag steers next cycle's memory data; reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= owner_for(f_gnt, l_gnt, l_we);
    end
  end

  assign f_rvalid = (r_owner == OWN_FETCH);
  assign l_rvalid = (r_owner == OWN_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_rdata <= '0;
      r_l_rdata <= '0;
    end else begin
      if (f_rvalid) r_f_rdata <= mem_rdata;
      if (l_rvalid) r_l_rdata <= mem_rdata;
    end
  end

  assign f_rdata = f_rvalid ? mem_rdata : r_f_rdata;
  assign l_rdata = l_rvalid ? mem_rdata : r_l_rdata;

  always_comb begin
    o_dbg               = '0;
    o_dbg.lock          = r_lock;
    o_dbg.owner         = r_owner;
    o_dbg.starve        = r_starve;
    o_dbg.rr_prio_fetch = w_prio_fetch;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a rule-level model.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int STARVE_MAX = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              f_req = 1'b0, f_gnt, f_rvalid, f_stall;
  logic [ADDR_W-1:0] f_addr = '0;
  logic [DATA_W-1:0] f_rdata;
  logic              l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0, l_gnt, l_rvalid;
  logic [ADDR_W-1:0] l_addr = '0;
  logic [DATA_W-1:0] l_wdata = '0, l_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  dbg_t              dbg;

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_stall(f_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .o_dbg(dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int a);
    case (a)
      0:       return 32'h00500313;
      1:       return 32'h00a00393;
      2:       return 32'h00730433;
      3:       return 32'h00000013;
      default: return 32'hA5000000 ^ (a * 32'h00010203);
    endcase
  endfunction

  // Synchronous RAM the arbiter drives: one-cycle read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W:0]   exp_q[$];   // {is_fetch, data}
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                ref_loaded = 1'b0;
  bit                m_locked = 1'b0;
  bit                m_last_f = 1'b0;
  int                m_wait = 0;
  logic [ADDR_W-1:0] m_addr_hold = '0;
  logic [DATA_W-1:0] m_wdata_hold = '0, m_f_hold = '0, m_l_hold = '0;

  always @(negedge clk) begin
    bit ef, el, rf, rl;
    logic [DATA_W:0]   r;
    logic [DATA_W-1:0] rd;
    #2;
    if (!ref_loaded) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      ref_loaded = 1'b1;
    end
    if (!rst_n) begin
      exp_q.delete();
      m_locked = 0; m_last_f = 0; m_wait = 0;
      m_addr_hold = '0; m_wdata_hold = '0; m_f_hold = '0; m_l_hold = '0;
      chk("rst_f_gnt", f_gnt, 0);
      chk("rst_l_gnt", l_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_f_rvalid", f_rvalid, 0);
      chk("rst_l_rvalid", l_rvalid, 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_l_rdata", l_rdata, 0);
      chk("rst_f_stall", f_stall, f_req);
    end else begin
      rf = 0; rl = 0; rd = '0;
      if (exp_q.size() > 0) begin
        r  = exp_q.pop_front();
        rf = r[DATA_W];
        rl = !r[DATA_W];
        rd = r[DATA_W-1:0];
      end
      if (rf) m_f_hold = rd;
      if (rl) m_l_hold = rd;
      chk("f_rvalid", f_rvalid, rf);
      chk("l_rvalid", l_rvalid, rl);
      chk("f_rdata", f_rdata, m_f_hold);
      chk("l_rdata", l_rdata, m_l_hold);

      ef = 0; el = 0;
      if (f_req && m_wait >= STARVE_MAX) ef = 1;
      else if (m_locked) el = l_req;
      else if (f_req && l_req) begin ef = !m_last_f; el = m_last_f; end
      else begin ef = f_req; el = l_req; end

      chk("f_gnt", f_gnt, ef);
      chk("l_gnt", l_gnt, el);
      chk("f_stall", f_stall, f_req && !ef);
      chk("mem_en", mem_en, ef || el);
      chk("mem_we", mem_we, el && l_we);
      chk("mem_addr", mem_addr, ef ? f_addr : (el ? l_addr : m_addr_hold));
      chk("mem_wdata", mem_wdata, el ? l_wdata : m_wdata_hold);

      if (ef) exp_q.push_back({1'b1, ref_mem[f_addr]});
      else if (el && !l_we) exp_q.push_back({1'b0, ref_mem[l_addr]});
      if (el && l_we) ref_mem[l_addr] = l_wdata;
      if (ef) m_addr_hold = f_addr;
      else if (el) begin m_addr_hold = l_addr; m_wdata_hold = l_wdata; end
      m_wait = ef ? 0 : (f_req ? m_wait + 1 : 0);
      if (!m_locked) m_locked = el && l_lock;
      else if ((el && !l_lock) || !l_req) m_locked = 0;
      if (ef) m_last_f = 1;
      else if (el) m_last_f = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fr, input logic [ADDR_W-1:0] fa, input logic lr,
                       input logic lw, input logic [ADDR_W-1:0] la,
                       input logic [DATA_W-1:0] ld, input logic lk);
    @(negedge clk);
    f_req = fr; f_addr = fa;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = lk;
    #3;
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; f_req = 0; l_req = 0; l_lock = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] lit [4];
  initial begin
    int lcnt, fidx;
    logic stall_at;
    logic fr, lr, lw, lk, f_pend, l_pend;
    logic [ADDR_W-1:0] fa, la;
    logic [DATA_W-1:0] ld;

    lit[0] = 32'h00500313; lit[1] = 32'h00a00393;
    lit[2] = 32'h00730433; lit[3] = 32'h00000013;

    // Requests raised while in reset must not be granted.
    f_req = 1; l_req = 1;
    repeat (2) @(negedge clk);
    #3;
    chk("t_rst_fgnt", f_gnt, 0);
    chk("t_rst_lgnt", l_gnt, 0);
    chk("t_rst_memen", mem_en, 0);
    @(negedge clk);
    f_req = 0; l_req = 0; rst_n = 1;

    // Fetch of the first four program words.
    for (int k = 0; k < 4; k++) begin
      drive(1, ADDR_W'(k), 0, 0, '0, '0, 0);
      chk("t038_gnt", f_gnt, 1);
      if (k > 0) begin
        chk("t038_rv", f_rvalid, 1);
        chk("t038_data", f_rdata, lit[k-1]);
      end
    end
    idle();
    chk("t038_rv", f_rvalid, 1);
    chk("t038_data", f_rdata, lit[3]);

    // Loader read of address 2 with fetch idle.
    drive(0, '0, 1, 0, 10'd2, '0, 0);
    chk("t043_gnt", l_gnt, 1);
    idle();
    chk("t043_lrv", l_rvalid, 1);
    chk("t043_ldata", l_rdata, 32'h00730433);
    chk("t043_frv", f_rvalid, 0);

    // Loader write then fetch of the same word.
    drive(0, '0, 1, 1, 10'd5, 32'hDEADBEEF, 0);
    chk("t040_wgnt", l_gnt, 1);
    drive(1, 10'd5, 0, 0, '0, '0, 0);
    chk("t040_lrv", l_rvalid, 0);
    chk("t040_fgnt", f_gnt, 1);
    idle();
    chk("t040_frv", f_rvalid, 1);
    chk("t040_fdata", f_rdata, 32'hDEADBEEF);
    chk("t040_lrv2", l_rvalid, 0);

    // Continuous contention from a fresh reset alternates F,L,F,L.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, ADDR_W'(i), 1, 0, ADDR_W'(i + 16), '0, 0);
      chk("t039_fgnt", f_gnt, (i % 2) == 0);
      chk("t039_lgnt", l_gnt, (i % 2) == 1);
      chk("t039_stall", f_stall, (i % 2) == 1);
    end

    // Locked loader burst against a waiting fetch.
    drive(1, '0, 0, 0, '0, '0, 0);
    lcnt = 0; fidx = 0; stall_at = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(1, ADDR_W'(k), 1, 0, ADDR_W'(k + 32), '0, 1);
      if (fidx == 0 && f_gnt) begin fidx = k + 1; stall_at = f_stall; end
      if (fidx == 0 && l_gnt) lcnt++;
    end
    chk("t041_lcnt", lcnt, 15);
    chk("t041_fidx", fidx, 16);
    chk("t041_stall", stall_at, 0);
    idle();
    idle();

    // Reset lands in the cycle after a fetch grant.
    drive(1, 10'd1, 0, 0, '0, '0, 0);
    chk("t042_gnt", f_gnt, 1);
    @(negedge clk);
    rst_n = 0; f_req = 0;
    #3;
    chk("t042_rv_rst", f_rvalid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #3;
    chk("t042_rv_after", f_rvalid, 0);
    chk("t042_rdata_rst", f_rdata, 0);
    drive(1, '0, 0, 0, '0, '0, 0);
    idle();
    chk("t042_rv", f_rvalid, 1);
    chk("t042_data", f_rdata, 32'h00500313);

    // Randomized traffic; requests are held until granted.
    f_pend = 0; l_pend = 0;
    fr = 0; lr = 0; lw = 0; lk = 0; fa = '0; la = '0; ld = '0;
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        f_pend = 0; l_pend = 0;
        continue;
      end
      if (!f_pend) begin
        fr = ($urandom_range(0, 99) < 65);
        fa = ADDR_W'($urandom_range(0, DEPTH - 1));
      end
      if (!l_pend) begin
        lr = ($urandom_range(0, 99) < (((c / 150) % 2) ? 95 : 45));
        lw = ($urandom_range(0, 99) < 35);
        la = ADDR_W'($urandom_range(0, DEPTH - 1));
        ld = DATA_W'($urandom);
        lk = ($urandom_range(0, 99) < 60);
      end
      drive(fr, fa, lr, lw, la, ld, lk);
      f_pend = fr && !f_gnt;
      l_pend = lr && !l_gnt;
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the shared instruction memory.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 f_req  input  1  fetch-side read request; held until granted.
REQ-006 f_addr  input  ADDR_W  fetch word address.
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  fetch read data valid.
REQ-009 f_rdata  output  DATA_W  fetch read data.
REQ-010 f_stall  output  1  f_req & ~f_gnt; drives the fetch stage stall.
REQ-011 l_req  input  1  loader/debug request; held until granted.
REQ-012 l_we  input  1  loader write (1) or read (0).
REQ-013 l_addr  input  ADDR_W  loader word address.
REQ-014 l_wdata  input  DATA_W  loader write data.
REQ-015 l_lock  input  1  loader burst lock; sampled with l_gnt.
REQ-016 l_gnt  output  1  loader request accepted this cycle.
REQ-017 l_rvalid  output  1  loader read data valid (reads only).
REQ-018 l_rdata  output  DATA_W  loader read data.
REQ-019 mem_en, mem_we  output  1 each  memory enable / write enable.
REQ-020 mem_addr  output  ADDR_W;  mem_wdata  output  DATA_W;  mem_rdata  input  DATA_W (synchronous, 1-cycle read latency).

Function
REQ-021 At most one of f_gnt, l_gnt SHALL be high in any cycle; a grant is combinational from current requests and state.
REQ-022 Single requester: that requester SHALL be granted the same cycle.
REQ-023 Both requesting, unlocked: round-robin — grant the requester not granted most recently; rr pointer updates only on a grant.
REQ-024 On grant, mem_en=1, and mem_addr/mem_we/mem_wdata SHALL come from the granted requester; fetch grants force mem_we=0.
REQ-025 No grant: mem_en=0, mem_we=0, mem_addr/mem_wdata hold last value.
REQ-026 Lock FSM states UNLOCKED, LOCKED; UNLOCKED->LOCKED when l_gnt & l_lock; LOCKED->UNLOCKED when l_gnt & ~l_lock, or a cycle with ~l_req.
REQ-027 In LOCKED, f_gnt SHALL be 0 regardless of f_req.
REQ-028 Read response: one cycle after a read grant, the owner's rvalid SHALL be 1 for exactly one cycle with rdata = mem_rdata; a registered owner tag routes it.
REQ-029 Loader writes SHALL produce no rvalid.
REQ-030 Back-to-back grants every cycle SHALL sustain one access per cycle; responses keep grant order.
REQ-031 f_rdata/l_rdata not owning the current response SHALL hold their last value.
REQ-032 Fetch starvation guard: a 4-bit counter of consecutive cycles with f_req & ~f_gnt; at 15 the fetch side SHALL be granted next cycle even if LOCKED, counter clears on f_gnt.

Reset
REQ-033 On rst_n low: f_rvalid=l_rvalid=0, rr pointer favours fetch, FSM=UNLOCKED, starvation counter=0, owner tag cleared, rdata outputs 0.
REQ-034 Reset mid-access SHALL discard the in-flight response; no rvalid after deassertion until a new grant.
REQ-035 Grants are combinational; during reset f_gnt=l_gnt=0 and mem_en=0.

Structure
REQ-036 Shared package holds: owner-tag encoding (NONE, FETCH, LOAD), lock-state encoding, starvation limit constant 15.
REQ-037 One sub-module rr_arb2 (2-way round-robin grant with pointer) is natural; remaining logic in imem_arbiter.

Verification
REQ-038 Fetch only, f_addr 0..3 consecutive -> f_gnt every cycle, f_rvalid next cycle with 0x00500313, 0x00a00393, 0x00730433, 0x00000013.
REQ-039 Both request continuously, unlocked -> grants alternate F,L,F,L; f_stall high on loader cycles.
REQ-040 Loader write addr 5 data 0xDEADBEEF, then fetch addr 5 -> no l_rvalid; f_rdata=0xDEADBEEF.
REQ-041 l_lock held 20 cycles with f_req high -> loader granted 15 cycles, fetch granted on 16th, f_stall low that cycle.
REQ-042 rst_n low in cycle after fetch read grant -> no f_rvalid; after release, next fetch addr 0 returns 0x00500313.
REQ-043 Loader read addr 2 while fetch idle -> l_rvalid one cycle later with 0x00730433, f_rvalid stays 0.
